pong_game_ctrl: RTL and testbench
=================================

Name: pong_game_ctrl

Overview:
Frame-rate game sequencer for the VGA Pong design. Sits between the hvsync/collision logic and the ball/bouncer datapath. Decides when the ball may move, when it is re-served to centre, and what step size it uses. Also keeps score, lives and the game phase, and is driven once per frame by the same end-of-frame tick that clears the collision detectors.

Parameters:
LIVES_INIT, 3, lives loaded at game start (1..3)
SERVE_FRAMES, 60, frames the ball is held at centre before play
MISS_FRAMES, 30, frames spent in MISS (miss indication) before re-serve or game over
MISS_Y, 9'd440, ball_y at or beyond which the ball counts as missed
HITS_PER_LEVEL, 4, paddle hits needed per step-size increase
MAX_STEP, 3'd5, maximum ball step (pixels/frame)

Ports:
clk  input  1  pixel clock (25 MHz)
reset  input  1  asynchronous, active-high reset
frame_tick  input  1  one-cycle pulse per frame (CounterY==500, CounterX==0)
start  input  1  level; begins a game from IDLE or GAME_OVER
pause  input  1  level; freezes PLAY and SERVE
paddle_hit  input  1  bouncer-top collision this frame; sampled only on frame_tick
ball_y  input  9  current ball top Y; sampled only on frame_tick
ball_move  output  1  one-cycle pulse: datapath applies one position update
ball_reload  output  1  one-cycle pulse: datapath loads centre position and default direction
ball_step  output  3  step size for the datapath, 1..MAX_STEP
state  output  3  IDLE=0, SERVE=1, PLAY=2, MISS=3, GAME_OVER=4
lives  output  2  remaining lives
score  output  10  paddle hits this game, saturating at 1023
miss_flash  output  1  high throughout MISS, for LED/colour use

Behaviour:
- Reset (async assert, sync release): state=IDLE, lives=0, score=0, ball_step=1, ball_move=0, ball_reload=0, miss_flash=0. Frame counter=0, hit counter=0.
- All decisions are made only in a cycle where frame_tick=1. Registered outputs change on the next clock edge, so latency is 1 cycle. ball_move and ball_reload are never high for more than 1 cycle and are never high together.
- IDLE: on frame_tick with start=1, go to SERVE. Load lives=LIVES_INIT, score=0, ball_step=1, hit counter=0, frame counter=0, and pulse ball_reload.
- SERVE: on each frame_tick with pause=0, increment the frame counter. When the counter reaches SERVE_FRAMES-1, go to PLAY and clear the counter. The ball does not move in SERVE. With pause=1 the counter holds.
- PLAY: on frame_tick with pause=0, pulse ball_move. Evaluate the sampled inputs in this order:
  1. ball_y>=MISS_Y: go to MISS, lives<=lives-1, clear the frame counter. This takes priority over paddle_hit; a simultaneous hit is not scored.
  2. else if paddle_hit: score<=score+1, saturating at 1023. Increment the hit counter. When it reaches HITS_PER_LEVEL, clear it and set ball_step<=min(ball_step+1, MAX_STEP).
- PLAY with pause=1: no ball_move, no scoring, no miss check.
- MISS: miss_flash=1. Count MISS_FRAMES frame_ticks, and pause is ignored here. At the end:
  - lives==0: go to GAME_OVER.
  - else: go to SERVE, pulse ball_reload, set ball_step=1, clear the hit counter. The score is kept.
- GAME_OVER: score and lives frozen. On frame_tick with start=1, behave exactly as the IDLE start.
- start is ignored in SERVE, PLAY and MISS.
- Unused state encodings recover to IDLE on the next clock.
- reset asserted mid-game: immediate return to reset values, with no pending pulse emitted.

Test Plan:
- Reset, start=1 for one frame_tick: ball_reload pulses once 1 cycle after the tick. state=SERVE, lives=3, score=0, step=1. After 60 more ticks state=PLAY, with no ball_move during SERVE.
- In PLAY, 8 ticks with paddle_hit=1 and ball_y=100: 8 ball_move pulses, score=8, ball_step=3. A further 20 hits leave ball_step at 5 (saturated).
- In PLAY, tick with ball_y=440 and paddle_hit=1: state=MISS, lives 3->2, score unchanged, miss_flash=1. After 30 ticks: state=SERVE, ball_reload pulses, ball_step=1.
- Three consecutive misses from game start: after the third MISS period state=GAME_OVER and lives=0. start=1 then restarts with score=0 and lives=3.
- pause=1 for 10 ticks in PLAY and then in SERVE: no ball_move, counters and score frozen. Resumes exactly where it stopped when pause=0.
- Assert reset while in MISS, between frame_ticks: all outputs take reset values immediately, with no ball_reload after release.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// Frame-rate sequencer for VGA Pong: serve/play/miss phases, ball move/reload pulses,
// step-size levelling, score and lives. All decisions are taken on frame_tick.
module pong_game_ctrl #(
    parameter int          LIVES_INIT     = 3,
    parameter int          SERVE_FRAMES   = 60,
    parameter int          MISS_FRAMES    = 30,
    parameter logic [8:0]  MISS_Y         = 9'd440,
    parameter int          HITS_PER_LEVEL = 4,
    parameter logic [2:0]  MAX_STEP       = 3'd5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       pause,
    input  logic       paddle_hit,
    input  logic [8:0] ball_y,
    output logic       ball_move,
    output logic       ball_reload,
    output logic [2:0] ball_step,
    output logic [2:0] state,
    output logic [1:0] lives,
    output logic [9:0] score,
    output logic       miss_flash
);

    localparam int FMAX = (SERVE_FRAMES > MISS_FRAMES) ? SERVE_FRAMES : MISS_FRAMES;
    localparam int CW   = $clog2(FMAX + 1);
    localparam int HW   = $clog2(HITS_PER_LEVEL + 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SERVE     = 3'd1,
        ST_PLAY      = 3'd2,
        ST_MISS      = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      lives_q, lives_d;
    logic [9:0]      score_q, score_d;
    logic [2:0]      step_q, step_d;
    logic [CW-1:0]   frame_cnt_q, frame_cnt_d;
    logic [HW-1:0]   hit_cnt_q, hit_cnt_d;
    logic            move_q, move_d;
    logic            reload_q, reload_d;
    logic            flash_q, flash_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            lives_q     <= 2'd0;
            score_q     <= 10'd0;
            step_q      <= 3'd1;
            frame_cnt_q <= '0;
            hit_cnt_q   <= '0;
            move_q      <= 1'b0;
            reload_q    <= 1'b0;
            flash_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            score_q     <= score_d;
            step_q      <= step_d;
            frame_cnt_q <= frame_cnt_d;
            hit_cnt_q   <= hit_cnt_d;
            move_q      <= move_d;
            reload_q    <= reload_d;
            flash_q     <= flash_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        score_d     = score_q;
        step_d      = step_q;
        frame_cnt_d = frame_cnt_q;
        hit_cnt_d   = hit_cnt_q;
        move_d      = 1'b0;
        reload_d    = 1'b0;

        case (state_q)
            ST_IDLE, ST_GAME_OVER: begin
                if (frame_tick && start) begin
                    state_d     = ST_SERVE;
                    lives_d     = 2'(LIVES_INIT);
                    score_d     = 10'd0;
                    step_d      = 3'd1;
                    hit_cnt_d   = '0;
                    frame_cnt_d = '0;
                    reload_d    = 1'b1;
                end
            end
            ST_SERVE: begin
                if (frame_tick && !pause) begin
                    if (frame_cnt_q == CW'(SERVE_FRAMES - 1)) begin
                        state_d     = ST_PLAY;
                        frame_cnt_d = '0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
            end
            ST_PLAY: begin
                if (frame_tick && !pause) begin
                    move_d = 1'b1;
                    // A miss outranks a same-frame paddle hit, which then goes unscored.
                    if (ball_y >= MISS_Y) begin
                        state_d     = ST_MISS;
                        frame_cnt_d = '0;
                        if (lives_q != 2'd0) begin
                            lives_d = lives_q - 2'd1;
                        end
                    end else if (paddle_hit) begin
                        if (score_q != 10'd1023) begin
                            score_d = score_q + 10'd1;
                        end
                        if (hit_cnt_q == HW'(HITS_PER_LEVEL - 1)) begin
                            hit_cnt_d = '0;
                            if (step_q < MAX_STEP) begin
                                step_d = step_q + 3'd1;
                            end
                        end else begin
                            hit_cnt_d = hit_cnt_q + 1'b1;
                        end
                    end
                end
            end
            ST_MISS: begin
                if (frame_tick) begin
                    if (frame_cnt_q == CW'(MISS_FRAMES - 1)) begin
                        frame_cnt_d = '0;
                        if (lives_q == 2'd0) begin
                            state_d = ST_GAME_OVER;
                        end else begin
                            state_d   = ST_SERVE;
                            reload_d  = 1'b1;
                            step_d    = 3'd1;
                            hit_cnt_d = '0;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        flash_d = (state_d == ST_MISS);
    end

    assign ball_move   = move_q;
    assign ball_reload = reload_q;
    assign ball_step   = step_q;
    assign state       = state_q;
    assign lives       = lives_q;
    assign score       = score_q;
    assign miss_flash  = flash_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: a vector table for the opening of a game plus
// hand-written sequences for serve/miss timing, pause, game over, restart and reset.
module tb_pong_game_ctrl;

    localparam int IDLE = 0, SERVE = 1, PLAY = 2, MISS = 3, GOVER = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       paddle_hit = 1'b0;
    logic [8:0] ball_y = 9'd0;
    logic       ball_move, ball_reload, miss_flash;
    logic [2:0] ball_step, state;
    logic [1:0] lives;
    logic [9:0] score;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pong_game_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .start      (start),
        .pause      (pause),
        .paddle_hit (paddle_hit),
        .ball_y     (ball_y),
        .ball_move  (ball_move),
        .ball_reload(ball_reload),
        .ball_step  (ball_step),
        .state      (state),
        .lives      (lives),
        .score      (score),
        .miss_flash (miss_flash)
    );

    typedef struct {
        logic       s, p, h;
        logic [8:0] y;
        int         st, lv, sc, stp, mv, rl, fl;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(logic s, logic p, logic h, logic [8:0] y,
                                int st, int lv, int sc, int stp, int mv, int rl, int fl);
        vec_t v;
        v.s = s; v.p = p; v.h = h; v.y = y;
        v.st = st; v.lv = lv; v.sc = sc; v.stp = stp; v.mv = mv; v.rl = rl; v.fl = fl;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int st, input int lv, input int sc,
                           input int stp, input int mv, input int rl, input int fl);
        chk({tag, ".state"},  int'(state),       st);
        chk({tag, ".lives"},  int'(lives),       lv);
        chk({tag, ".score"},  int'(score),       sc);
        chk({tag, ".step"},   int'(ball_step),   stp);
        chk({tag, ".move"},   int'(ball_move),   mv);
        chk({tag, ".reload"}, int'(ball_reload), rl);
        chk({tag, ".flash"},  int'(miss_flash),  fl);
    endtask

    // One frame: a tick cycle (outputs checked 1 cycle later) then an idle cycle
    // in which both pulses must already have dropped.
    task automatic frame(input string tag, input logic s, input logic p, input logic h,
                         input logic [8:0] y, input int st, input int lv, input int sc,
                         input int stp, input int mv, input int rl, input int fl);
        @(negedge clk);
        start = s; pause = p; paddle_hit = h; ball_y = y; frame_tick = 1'b1;
        @(posedge clk); #1;
        chk_all(tag, st, lv, sc, stp, mv, rl, fl);
        @(negedge clk);
        frame_tick = 1'b0;
        @(posedge clk); #1;
        chk({tag, ".pulse_width"}, int'({ball_move, ball_reload}), 0);
        $display("frame %s: state=%0d lives=%0d score=%0d step=%0d move=%0d reload=%0d flash=%0d",
                 tag, state, lives, score, ball_step, ball_move, ball_reload, miss_flash);
    endtask

    // SERVE lasts 60 unpaused ticks; the 60th moves to PLAY without a move pulse.
    task automatic serve_to_play(input int lv, input int sc);
        for (int i = 0; i < 59; i++) frame("serve", 1'b0, 1'b0, 1'b1, 9'd100, SERVE, lv, sc, 1, 0, 0, 0);
        frame("serve_end", 1'b0, 1'b0, 1'b0, 9'd100, PLAY, lv, sc, 1, 0, 0, 0);
    endtask

    task automatic miss_hold(input int lv, input int sc, input int stp, input int n);
        for (int i = 0; i < n; i++) frame("miss_hold", 1'b1, (i % 2) == 0, 1'b1, 9'd100, MISS, lv, sc, stp, 0, 0, 1);
    endtask

    initial begin
        vecs[0]  = mk(0, 0, 0, 9'd100, IDLE,  0, 0, 1, 0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 9'd100, SERVE, 3, 0, 1, 0, 1, 0);
        vecs[2]  = mk(0, 0, 1, 9'd100, PLAY,  3, 0, 1, 0, 0, 0);
        vecs[3]  = mk(0, 0, 1, 9'd100, PLAY,  3, 1, 1, 1, 0, 0);
        vecs[4]  = mk(0, 0, 1, 9'd100, PLAY,  3, 2, 1, 1, 0, 0);
        vecs[5]  = mk(0, 0, 1, 9'd100, PLAY,  3, 3, 1, 1, 0, 0);
        vecs[6]  = mk(0, 0, 1, 9'd100, PLAY,  3, 4, 2, 1, 0, 0);
        vecs[7]  = mk(0, 0, 1, 9'd100, PLAY,  3, 5, 2, 1, 0, 0);
        vecs[8]  = mk(0, 0, 1, 9'd100, PLAY,  3, 6, 2, 1, 0, 0);
        vecs[9]  = mk(0, 0, 1, 9'd100, PLAY,  3, 7, 2, 1, 0, 0);
        vecs[10] = mk(0, 0, 1, 9'd100, PLAY,  3, 8, 3, 1, 0, 0);
        vecs[11] = mk(0, 0, 0, 9'd100, PLAY,  3, 8, 3, 1, 0, 0);
        vecs[12] = mk(1, 1, 1, 9'd440, PLAY,  3, 8, 3, 0, 0, 0);
        vecs[13] = mk(1, 0, 0, 9'd439, PLAY,  3, 8, 3, 1, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk_all("reset", IDLE, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        // Opening vectors: idle, start, then first serve tick sequence below.
        for (int i = 0; i < 2; i++)
            frame($sformatf("vec%0d", i), vecs[i].s, vecs[i].p, vecs[i].h, vecs[i].y,
                  vecs[i].st, vecs[i].lv, vecs[i].sc, vecs[i].stp, vecs[i].mv, vecs[i].rl, vecs[i].fl);
        for (int i = 0; i < 59; i++) frame("serve", 1'b1, 1'b0, 1'b1, 9'd100, SERVE, 3, 0, 1, 0, 0, 0);
        for (int i = 2; i < 14; i++)
            frame($sformatf("vec%0d", i), vecs[i].s, vecs[i].p, vecs[i].h, vecs[i].y,
                  vecs[i].st, vecs[i].lv, vecs[i].sc, vecs[i].stp, vecs[i].mv, vecs[i].rl, vecs[i].fl);

        // 20 more hits: step climbs to 4 then saturates at 5.
        for (int i = 1; i <= 20; i++)
            frame("hit_sat", 1'b0, 1'b0, 1'b1, 9'd100, PLAY, 3, 8 + i, (i < 4) ? 3 : (i < 8) ? 4 : 5, 1, 0, 0);

        // Pause in PLAY: nothing moves, scores or misses.
        for (int i = 0; i < 10; i++) frame("play_pause", 1'b0, 1'b1, 1'b1, 9'd450, PLAY, 3, 28, 5, 0, 0, 0);
        frame("play_resume", 1'b0, 1'b0, 1'b1, 9'd100, PLAY, 3, 29, 5, 1, 0, 0);

        // Miss with simultaneous hit: not scored.
        frame("miss1", 1'b0, 1'b0, 1'b1, 9'd440, MISS, 2, 29, 5, 1, 0, 1);
        miss_hold(2, 29, 5, 29);
        frame("miss1_end", 1'b0, 1'b0, 1'b0, 9'd100, SERVE, 2, 29, 1, 0, 1, 0);

        // Pause in SERVE holds the counter: still a full 60 ticks afterwards.
        for (int i = 0; i < 10; i++) frame("serve_pause", 1'b0, 1'b1, 1'b0, 9'd100, SERVE, 2, 29, 1, 0, 0, 0);
        serve_to_play(2, 29);

        frame("miss2", 1'b0, 1'b0, 1'b0, 9'd500, MISS, 1, 29, 1, 1, 0, 1);
        miss_hold(1, 29, 1, 29);
        frame("miss2_end", 1'b0, 1'b0, 1'b0, 9'd100, SERVE, 1, 29, 1, 0, 1, 0);
        serve_to_play(1, 29);

        frame("miss3", 1'b0, 1'b0, 1'b0, 9'd511, MISS, 0, 29, 1, 1, 0, 1);
        miss_hold(0, 29, 1, 29);
        frame("miss3_end", 1'b0, 1'b0, 1'b0, 9'd100, GOVER, 0, 29, 1, 0, 0, 0);
        frame("gover_hold", 1'b0, 1'b0, 1'b1, 9'd100, GOVER, 0, 29, 1, 0, 0, 0);
        frame("restart", 1'b1, 1'b0, 1'b0, 9'd100, SERVE, 3, 0, 1, 0, 1, 0);

        // Reset between ticks on the frame before MISS would end.
        serve_to_play(3, 0);
        frame("miss4", 1'b0, 1'b0, 1'b0, 9'd440, MISS, 2, 0, 1, 1, 0, 1);
        miss_hold(2, 0, 1, 29);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_all("async_reset", IDLE, 0, 0, 1, 0, 0, 0);
        @(posedge clk); #1;
        chk_all("reset_hold", IDLE, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        frame("post_reset1", 1'b0, 1'b0, 1'b0, 9'd100, IDLE, 0, 0, 1, 0, 0, 0);
        frame("post_reset2", 1'b0, 1'b0, 1'b1, 9'd440, IDLE, 0, 0, 1, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
